// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: register map, CFG layout, event ids.
package perf_counter_bank_pkg;

    localparam int unsigned ADDR_CTRL = 0;
    localparam int unsigned ADDR_OVF  = 1;
    localparam int unsigned ADDR_MASK = 2;
    localparam int unsigned CH_BASE   = 4;
    localparam int unsigned CH_STRIDE = 4;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_CLR = 1;

    localparam int unsigned CFG_EN    = 8;
    localparam int unsigned CFG_EDGE  = 9;
    localparam int unsigned CFG_STALL = 10;

    localparam int unsigned EVT_CYCLE  = 0;
    localparam int unsigned EVT_RETIRE = 1;

    typedef enum logic [1:0] {
        REG_CFG  = 2'd0,
        REG_LO   = 2'd1,
        REG_HI   = 2'd2,
        REG_RSVD = 2'd3
    } ch_reg_e;

    typedef struct packed {
        logic       stall_gate;
        logic       edge_mode;
        logic       en;
        logic [2:0] sel;
    } cfg_t;

    function automatic cfg_t cfg_from_word(input logic [31:0] w);
        cfg_t c;
        c.sel        = w[2:0];
        c.en         = w[CFG_EN];
        c.edge_mode  = w[CFG_EDGE];
        c.stall_gate = w[CFG_STALL];
        return c;
    endfunction

    function automatic logic [31:0] cfg_to_word(input cfg_t c);
        logic [31:0] w;
        w            = '0;
        w[2:0]       = c.sel;
        w[CFG_EN]    = c.en;
        w[CFG_EDGE]  = c.edge_mode;
        w[CFG_STALL] = c.stall_gate;
        return w;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// MMIO load/store port between the datapath and the performance counter bank.
interface perf_counter_bank_if
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (output addr, we, re, wdata, input rdata, rvalid);
    modport slave  (input addr, we, re, wdata, output rdata, rvalid);
endinterface

// File: rtl/perf_counter_bank_counter.sv
// One counter channel: event select, edge detect, stall gating, wrapping counter and write ports.
module perf_counter_bank_counter
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned CNT_W   = 48,
    parameter int unsigned NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_EVT-1:0] events,
    input  logic               global_en,
    input  logic               stall,
    input  cfg_t               cfg,
    input  logic               clear,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic [31:0]        wdata,
    output logic [63:0]        value,
    output logic               wrap
);
    localparam int unsigned SEL_W = $clog2(NUM_EVT);

    logic [NUM_EVT-1:0] events_q;
    logic [CNT_W-1:0]   cnt;
    logic [SEL_W-1:0]   sel;
    logic [63:0]        wr_val;
    logic               hit;
    logic               inc;

    assign sel   = cfg.sel[SEL_W-1:0];
    assign value = 64'(cnt);

    always_comb begin
        hit    = cfg.edge_mode ? (events[sel] & ~events_q[sel]) : events[sel];
        inc    = global_en & cfg.en & hit & ~(cfg.stall_gate & stall);
        wr_val = wr_lo ? {value[63:32], wdata} : {wdata, value[31:0]};
        // A wrap only counts when the increment actually lands (not overridden by clear/write).
        wrap   = inc & ~clear & ~(wr_lo | wr_hi) & (&cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_q <= '0;
            cnt      <= '0;
        end else begin
            events_q <= events;
            if (clear) begin
                cnt <= '0;
            end else if (wr_lo || wr_hi) begin
                cnt <= wr_val[CNT_W-1:0];
            end else if (inc) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of programmable event counters on the MMIO path with a maskable overflow interrupt.
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_CNT = 4,
    parameter int unsigned CNT_W   = 48,
    parameter int unsigned NUM_EVT = 8,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               stall,
    input  logic [NUM_EVT-1:0] events,
    perf_counter_bank_if.slave bus,
    output logic               irq
);
    localparam int unsigned CH_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic [ADDR_W-1:0]  addr;
    logic [31:0]        off;
    logic               is_ctrl, is_ovf, is_mask, in_ch;
    logic [CH_W-1:0]    ch;
    ch_reg_e            reg_sel;
    logic [NUM_EVT-1:0] events_int;
    logic               clear_all;
    logic [NUM_CNT-1:0] wr_lo, wr_hi, wr_cfg, wrap, ovf_clr;
    logic [63:0]        value [NUM_CNT];
    logic [63:0]        sel_value;
    cfg_t               sel_cfg;
    logic [31:0]        rd_val;

    logic               global_en;
    logic [NUM_CNT-1:0] ovf, mask;
    cfg_t               cfg [NUM_CNT];
    logic [31:0]        shadow;
    logic [CH_W-1:0]    shadow_ch;
    logic               shadow_valid;
    logic [31:0]        rdata;
    logic               rvalid;

    assign addr       = bus.addr;
    assign events_int = events | NUM_EVT'(1);
    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;

    always_comb begin
        is_ctrl   = (32'(addr) == ADDR_CTRL);
        is_ovf    = (32'(addr) == ADDR_OVF);
        is_mask   = (32'(addr) == ADDR_MASK);
        in_ch     = (32'(addr) >= CH_BASE) && (32'(addr) < CH_BASE + CH_STRIDE * NUM_CNT);
        off       = 32'(addr) - CH_BASE;
        ch        = CH_W'(off / CH_STRIDE);
        reg_sel   = ch_reg_e'(off[1:0]);
        clear_all = bus.we & is_ctrl & bus.wdata[CTRL_CLR];
        ovf_clr   = (bus.we && is_ovf) ? bus.wdata[NUM_CNT-1:0] : '0;
        wr_lo     = '0;
        wr_hi     = '0;
        wr_cfg    = '0;
        sel_value = '0;
        sel_cfg   = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (in_ch && ch == CH_W'(i)) begin
                wr_lo[i]  = bus.we && reg_sel == REG_LO;
                wr_hi[i]  = bus.we && reg_sel == REG_HI;
                wr_cfg[i] = bus.we && reg_sel == REG_CFG;
                sel_value = value[i];
                sel_cfg   = cfg[i];
            end
        end
        rd_val = '0;
        if (is_ctrl) begin
            rd_val = 32'(global_en);
        end else if (is_ovf) begin
            rd_val = 32'(ovf);
        end else if (is_mask) begin
            rd_val = 32'(mask);
        end else if (in_ch) begin
            case (reg_sel)
                REG_CFG: rd_val = cfg_to_word(sel_cfg);
                REG_LO:  rd_val = sel_value[31:0];
                REG_HI:  rd_val = (shadow_valid && shadow_ch == ch) ? shadow : sel_value[63:32];
                default: rd_val = '0;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
        perf_counter_bank_counter #(
            .CNT_W   (CNT_W),
            .NUM_EVT (NUM_EVT)
        ) u_cnt (
            .clk       (CLK),
            .rst_n     (reset_n),
            .events    (events_int),
            .global_en (global_en),
            .stall     (stall),
            .cfg       (cfg[i]),
            .clear     (clear_all),
            .wr_lo     (wr_lo[i]),
            .wr_hi     (wr_hi[i]),
            .wdata     (bus.wdata),
            .value     (value[i]),
            .wrap      (wrap[i])
        );
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            global_en    <= 1'b0;
            ovf          <= '0;
            mask         <= '0;
            shadow       <= '0;
            shadow_ch    <= '0;
            shadow_valid <= 1'b0;
            rdata        <= '0;
            rvalid       <= 1'b0;
            irq          <= 1'b0;
            for (int unsigned i = 0; i < NUM_CNT; i++) cfg[i] <= '0;
        end else begin
            irq    <= (|(ovf & mask)) & global_en;
            rvalid <= bus.re;
            if (bus.re) rdata <= rd_val;
            // LO read snapshots the high half so a following HI read of the same channel is tear-free.
            if (bus.re && in_ch && reg_sel == REG_LO) begin
                shadow       <= sel_value[63:32];
                shadow_ch    <= ch;
                shadow_valid <= 1'b1;
            end
            if (bus.we && is_ctrl) global_en <= bus.wdata[CTRL_EN];
            if (bus.we && is_mask) mask <= bus.wdata[NUM_CNT-1:0];
            ovf <= (ovf & ~ovf_clr) | wrap;
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (wr_cfg[i]) cfg[i] <= cfg_from_word(bus.wdata);
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Randomised and directed bench for perf_counter_bank against a cycle-level behavioural model.
module tb_perf_counter_bank;
    localparam int unsigned NUM_CNT = 4;
    localparam int unsigned CNT_W   = 48;
    localparam int unsigned NUM_EVT = 8;
    localparam int unsigned ADDR_W  = 6;
    localparam longint unsigned CMAX = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - CNT_W);

    logic               CLK = 1'b0;
    logic               reset_n = 1'b0;
    logic               stall = 1'b0;
    logic [NUM_EVT-1:0] events = '0;
    logic               irq;

    perf_counter_bank_if #(.ADDR_W(ADDR_W)) bus ();

    perf_counter_bank #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .NUM_EVT (NUM_EVT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .stall   (stall),
        .events  (events),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 CLK = ~CLK;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned    m_cnt [NUM_CNT];
    bit [31:0]          m_cfg [NUM_CNT];
    bit                 m_en = 0;
    bit [NUM_CNT-1:0]   m_ovf = '0, m_mask = '0;
    bit [NUM_EVT-1:0]   m_prev = '0;
    bit [31:0]          m_shadow = '0;
    int                 m_shadow_ch = -1;
    bit [31:0]          exp_rdata = '0;
    bit                 exp_rvalid = 0, exp_irq = 0;

    initial for (int c = 0; c < NUM_CNT; c++) begin m_cnt[c] = 0; m_cfg[c] = 0; end

    function automatic bit [31:0] model_read(input int unsigned a);
        int unsigned c, r;
        if (a == 0) return {31'b0, m_en};
        if (a == 1) return 32'(m_ovf);
        if (a == 2) return 32'(m_mask);
        if (a < 4 || a >= 4 + 4 * NUM_CNT) return 0;
        c = (a - 4) / 4;
        r = a % 4;
        case (r)
            0: return m_cfg[c];
            1: return m_cnt[c][31:0];
            2: return (m_shadow_ch == int'(c)) ? m_shadow : m_cnt[c][63:32];
            default: return 0;
        endcase
    endfunction

    always @(posedge CLK or negedge reset_n) begin : model
        bit [NUM_EVT-1:0] ev;
        bit [NUM_CNT-1:0] wraps, clr_mask;
        int unsigned      a, sel;
        bit               clr, hit, cnt_ev;
        if (!reset_n) begin
            for (int c = 0; c < NUM_CNT; c++) begin m_cnt[c] = 0; m_cfg[c] = 0; end
            m_en = 0; m_ovf = '0; m_mask = '0; m_prev = '0;
            m_shadow = '0; m_shadow_ch = -1;
            exp_rdata = '0; exp_rvalid = 0; exp_irq = 0;
        end else begin
            ev = events; ev[0] = 1'b1;
            a = 32'(bus.addr);
            exp_irq = ((m_ovf & m_mask) != 0) && m_en;
            exp_rvalid = bus.re;
            if (bus.re) begin
                exp_rdata = model_read(a);
                if (a >= 4 && a < 4 + 4 * NUM_CNT && a % 4 == 1) begin
                    m_shadow = m_cnt[(a - 4) / 4][63:32];
                    m_shadow_ch = int'((a - 4) / 4);
                end
            end
            clr = bus.we && a == 0 && bus.wdata[1];
            wraps = '0;
            for (int c = 0; c < NUM_CNT; c++) begin
                sel = (m_cfg[c] & 7) % NUM_EVT;
                hit = m_cfg[c][9] ? (ev[sel] && !m_prev[sel]) : ev[sel];
                cnt_ev = m_en && m_cfg[c][8] && hit && !(m_cfg[c][10] && stall);
                if (clr) m_cnt[c] = 0;
                else if (bus.we && a == 5 + 4 * c)
                    m_cnt[c] = ((m_cnt[c] & 64'hFFFF_FFFF_0000_0000) | 64'(bus.wdata)) & CMAX;
                else if (bus.we && a == 6 + 4 * c)
                    m_cnt[c] = ((64'(bus.wdata) << 32) | (m_cnt[c] & 64'hFFFF_FFFF)) & CMAX;
                else if (cnt_ev) begin
                    if (m_cnt[c] == CMAX) begin m_cnt[c] = 0; wraps[c] = 1'b1; end
                    else m_cnt[c] = m_cnt[c] + 1;
                end
            end
            clr_mask = (bus.we && a == 1) ? bus.wdata[NUM_CNT-1:0] : '0;
            m_ovf = (m_ovf & ~clr_mask) | wraps;
            if (bus.we && a == 0) m_en = bus.wdata[0];
            if (bus.we && a == 2) m_mask = bus.wdata[NUM_CNT-1:0];
            for (int c = 0; c < NUM_CNT; c++)
                if (bus.we && a == 4 + 4 * c) m_cfg[c] = bus.wdata & 32'h0000_0707;
            m_prev = ev;
        end
    end

    always @(negedge CLK) begin : compare
        check("rvalid", 64'(bus.rvalid), 64'(exp_rvalid));
        check("rdata", 64'(bus.rdata), 64'(exp_rdata));
        check("irq", 64'(irq), 64'(exp_irq));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cycle(input logic w, input logic r, input int unsigned a, input logic [31:0] d);
        bus.we = w; bus.re = r; bus.addr = ADDR_W'(a); bus.wdata = d;
        @(posedge CLK); #1;
        bus.we = 1'b0; bus.re = 1'b0;
    endtask

    task automatic wr(input int unsigned a, input logic [31:0] d);
        do_cycle(1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) do_cycle(1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic rd_check(input string name, input int unsigned a, input logic [31:0] exp);
        do_cycle(1'b0, 1'b1, a, 32'h0);
        check(name, 64'(bus.rdata), 64'(exp));
        check({name, "_rvalid"}, 64'(bus.rvalid), 64'd1);
    endtask

    initial begin
        int unsigned op, a;
        logic [31:0] d;
        bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0;

        // Reset held with activity on the inputs
        events = '1; stall = 1'b1; reset_n = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("irq_in_reset", 64'(irq), 64'd0);
        events = '0; stall = 1'b0; reset_n = 1'b1;
        for (int unsigned i = 0; i < 4 + 4 * NUM_CNT; i++) rd_check("reset_read", i, 32'h0);
        events = 8'h0F; idle(5); events = '0;
        rd_check("off_lo0", 5, 32'h0);
        wr(0, 32'h1); idle(5); wr(0, 32'h0);
        rd_check("noen_lo0", 5, 32'h0);

        // Cycle counting: 100 counted edges between enable and disable writes
        wr(4, 32'h100); wr(0, 32'h1); idle(99); wr(0, 32'h0);
        rd_check("cycles100", 5, 32'd100);
        rd_check("cfg0_read", 4, 32'h100);

        // Level vs edge on event 2
        wr(0, 32'h2); wr(4, 32'h0); wr(8, 32'h102); wr(12, 32'h302);
        wr(0, 32'h1);
        events = 8'h04; idle(5); events = '0; idle(2);
        wr(0, 32'h0);
        rd_check("level5", 9, 32'd5);
        rd_check("edge1", 13, 32'd1);

        // Stall gating: 3 of 10 counting cycles stalled
        wr(16, 32'h500); wr(0, 32'h3);
        for (int unsigned i = 0; i < 10; i++) begin
            stall = (i >= 3 && i <= 5);
            if (i == 9) wr(0, 32'h0); else idle(1);
        end
        stall = 1'b0;
        rd_check("stall7", 17, 32'd7);

        // Overflow and interrupt
        wr(0, 32'h2); wr(4, 32'h100); wr(6, 32'hFFFF); wr(5, 32'hFFFF_FFFE); wr(2, 32'h1);
        wr(0, 32'h1); idle(1); wr(4, 32'h0);
        check("irq_not_yet", 64'(irq), 64'd0);
        rd_check("ovf_set", 1, 32'h1);
        check("irq_after_wrap", 64'(irq), 64'd1);
        rd_check("wrap_lo", 5, 32'h0);
        rd_check("wrap_hi", 6, 32'h0);
        wr(5, 32'hFFFF_FFFF); wr(6, 32'hFFFF); wr(4, 32'h100);
        wr(1, 32'h1);
        wr(4, 32'h0);
        rd_check("ovf_set_beats_w1c", 1, 32'h1);
        wr(1, 32'hF);
        rd_check("ovf_cleared", 1, 32'h0);
        wr(0, 32'h0);

        // Tear-free 64-bit read
        wr(0, 32'h2); wr(8, 32'h100); wr(9, 32'hFFFF_FFFF); wr(10, 32'h0);
        wr(0, 32'h1);
        rd_check("tear_lo", 9, 32'hFFFF_FFFF);
        rd_check("tear_hi_shadow", 10, 32'h0);
        rd_check("other_lo", 13, 32'h0);
        rd_check("tear_hi_live", 10, 32'h1);
        wr(0, 32'h0);

        // Collisions and reserved addresses
        wr(0, 32'h2); wr(8, 32'h0); wr(4, 32'h100); wr(0, 32'h1); idle(3);
        wr(5, 32'h10);
        rd_check("write_beats_inc", 5, 32'h10);
        idle(2);
        wr(0, 32'h3);
        rd_check("clear_beats_inc", 5, 32'h0);
        wr(0, 32'h0);
        rd_check("rsvd3", 3, 32'h0);
        rd_check("rsvd7", 7, 32'h0);
        rd_check("unmapped63", 63, 32'h0);

        // Random traffic
        for (int unsigned n = 0; n < 2000; n++) begin
            events = NUM_EVT'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            op = $urandom_range(0, 9);
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4 + 4 * NUM_CNT - 1);
            d = $urandom;
            if (a == 0) d = {30'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0)};
            else if (a >= 4 && a % 4 == 0) d[8] = ($urandom_range(0, 3) != 0);
            else if (a >= 4 && a % 4 == 2 && $urandom_range(0, 1) == 1) d = 32'hFFFF;
            else if (a >= 4 && a % 4 == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (op <= 3) idle(1);
            else if (op <= 5) do_cycle(1'b0, 1'b1, a, 32'h0);
            else if (op == 6) do_cycle(1'b1, 1'b1, a, d);
            else wr(a, d);
        end
        events = '0; stall = 1'b0;

        // Reset arriving while a read result is being presented
        do_cycle(1'b0, 1'b1, 1, 32'h0);
        #2 reset_n = 1'b0;
        #1 check("rvalid_async_reset", 64'(bus.rvalid), 64'd0);
        check("rdata_async_reset", 64'(bus.rdata), 64'd0);
        @(posedge CLK); #1;
        reset_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
